// File: rtl/decode_pipe.sv
// decode_pipe: instruction decode stage with register file,
// hazard detection and the ID/EX pipeline register.
module decode_pipe #(
    parameter int DATA_W   = 32,
    parameter int NREGS    = 32,
    parameter bit SIGN_EXT = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       inst_in,
    input  logic              inst_valid,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              stall_out,
    output logic              jump,
    output logic              exception,
    output logic              equal,
    output logic              id_valid,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] data_1,
    output logic [DATA_W-1:0] data_2,
    output logic [3:0]        ex,
    output logic [2:0]        m,
    output logic [1:0]        wb
);

    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef struct packed {
        logic [3:0] ex;
        logic [2:0] m;
        logic [1:0] wb;
    } ctrl_t;

    logic [DATA_W-1:0] regs [NREGS];

    logic [5:0]        op;
    logic [4:0]        f_rs;
    logic [4:0]        f_rt;
    logic [4:0]        f_rd;
    logic [DATA_W-1:0] f_imm;
    logic [DATA_W-1:0] rd_1;
    logic [DATA_W-1:0] rd_2;
    logic              wr_ok;
    logic              known;
    logic              bubble;
    ctrl_t             ctrl;

    assign op   = inst_in[31:26];
    assign f_rs = inst_in[25:21];
    assign f_rt = inst_in[20:16];
    assign f_rd = inst_in[15:11];

    assign f_imm = SIGN_EXT ? DATA_W'($signed(inst_in[15:0]))
                            : DATA_W'(inst_in[15:0]);

    function automatic logic in_range(input logic [4:0] a);
        return 32'(a) < NREGS;
    endfunction

    // A write is real only for a non-zero, implemented register.
    assign wr_ok = wr_en && (wr_addr != 5'd0) && in_range(wr_addr);

    function automatic logic [DATA_W-1:0] rf_read(input logic [4:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if (a != 5'd0 && in_range(a)) begin
            if (BYPASS && wr_ok && wr_addr == a)
                v = wr_data;
            else
                v = regs[a[AW-1:0]];
        end
        return v;
    endfunction

    // Register file storage; reset clears every entry and drops writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    // Two forwarded read ports for rs and rt.
    always_comb begin
        rd_1 = rf_read(f_rs);
        rd_2 = rf_read(f_rt);
    end

    // Opcode to control-bundle decode; unknown opcodes give zero controls.
    always_comb begin
        ctrl  = '0;
        known = 1'b1;
        case (op)
            OP_RTYPE: ctrl = '{ex: 4'b1100, m: 3'b000, wb: 2'b10};
            OP_LW:    ctrl = '{ex: 4'b0001, m: 3'b010, wb: 2'b11};
            OP_SW:    ctrl = '{ex: 4'b0001, m: 3'b001, wb: 2'b00};
            OP_BEQ:   ctrl = '{ex: 4'b0010, m: 3'b100, wb: 2'b00};
            OP_J:     ctrl = '0;
            default:  known = 1'b0;
        endcase
    end

    // Load-use: the load in ID/EX targets a source of the incoming inst.
    assign stall_out = inst_valid && id_valid && m[1] &&
                       (rt != 5'd0) &&
                       (rt == f_rs || rt == f_rt);

    assign jump      = inst_valid && (op == OP_J);
    assign exception = inst_valid && !known;
    assign equal     = inst_valid && (rd_1 == rd_2);

    assign bubble = flush || stall_out || !inst_valid;

    // ID/EX stage register: bubbles clear only the valid and controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid <= 1'b0;
            ex       <= '0;
            m        <= '0;
            wb       <= '0;
            rs       <= '0;
            rt       <= '0;
            rd       <= '0;
            imm      <= '0;
            data_1   <= '0;
            data_2   <= '0;
        end else begin
            rs     <= f_rs;
            rt     <= f_rt;
            rd     <= f_rd;
            imm    <= f_imm;
            data_1 <= rd_1;
            data_2 <= rd_2;
            if (bubble) begin
                id_valid <= 1'b0;
                ex       <= '0;
                m        <= '0;
                wb       <= '0;
            end else begin
                id_valid <= 1'b1;
                ex       <= ctrl.ex;
                m        <= ctrl.m;
                wb       <= ctrl.wb;
            end
        end
    end

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed stimulus with a queue-based scoreboard
// checking every valid ID/EX output of decode_pipe.
module tb_decode_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_in;
    logic        inst_valid;
    logic        flush;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    logic        stall_out, jump, exception, equal, id_valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm, data_1, data_2;
    logic [3:0]  ex;
    logic [2:0]  m;
    logic [1:0]  wb;

    logic        b_stall, b_jump, b_exc, b_equal, b_valid;
    logic [4:0]  b_rs, b_rt, b_rd;
    logic [31:0] b_imm, b_d1, b_d2;
    logic [3:0]  b_ex;
    logic [2:0]  b_m;
    logic [1:0]  b_wb;

    int checks = 0;
    int errors = 0;
    int seen   = 0;
    int pushed = 0;

    typedef struct packed {
        logic [3:0]  ex;
        logic [2:0]  m;
        logic [1:0]  wb;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] d1;
        logic [31:0] d2;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    decode_pipe dut (
        .clk(clk), .rst(rst), .inst_in(inst_in),
        .inst_valid(inst_valid), .flush(flush),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .stall_out(stall_out), .jump(jump),
        .exception(exception), .equal(equal),
        .id_valid(id_valid), .rs(rs), .rt(rt), .rd(rd),
        .imm(imm), .data_1(data_1), .data_2(data_2),
        .ex(ex), .m(m), .wb(wb)
    );

    decode_pipe #(.SIGN_EXT(1'b0), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .inst_in(inst_in),
        .inst_valid(inst_valid), .flush(flush),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .stall_out(b_stall), .jump(b_jump),
        .exception(b_exc), .equal(b_equal),
        .id_valid(b_valid), .rs(b_rs), .rt(b_rt), .rd(b_rd),
        .imm(b_imm), .data_1(b_d1), .data_2(b_d2),
        .ex(b_ex), .m(b_m), .wb(b_wb)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] s,
                                          input logic [4:0] t,
                                          input logic [4:0] d);
        return {6'b000000, s, t, d, 11'd0};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] o,
                                          input logic [4:0] s,
                                          input logic [4:0] t,
                                          input logic [15:0] i);
        return {o, s, t, i};
    endfunction

    task automatic push(input logic [3:0] e, input logic [2:0] mm,
                        input logic [1:0] w, input logic [4:0] s,
                        input logic [4:0] t, input logic [4:0] d,
                        input logic [31:0] i, input logic [31:0] a,
                        input logic [31:0] b);
        exp_t x;
        x = '{ex: e, m: mm, wb: w, rs: s, rt: t, rd: d,
              imm: i, d1: a, d2: b};
        q.push_back(x);
        pushed++;
    endtask

    task automatic drive(input logic [31:0] i, input logic v,
                         input logic f, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd);
        @(posedge clk);
        #1;
        inst_in    = i;
        inst_valid = v;
        flush      = f;
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
    endtask

    // Scoreboard monitor: every valid ID/EX output must match the queue head.
    always @(negedge clk) begin
        if (id_valid === 1'b1) begin
            exp_t x;
            seen++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid got=1 want=0 t=%0t",
                         $time);
            end else begin
                x = q.pop_front();
                chk("sb_ex", 32'(ex), 32'(x.ex));
                chk("sb_m", 32'(m), 32'(x.m));
                chk("sb_wb", 32'(wb), 32'(x.wb));
                chk("sb_rs", 32'(rs), 32'(x.rs));
                chk("sb_rt", 32'(rt), 32'(x.rt));
                chk("sb_rd", 32'(rd), 32'(x.rd));
                chk("sb_imm", imm, x.imm);
                chk("sb_data_1", data_1, x.d1);
                chk("sb_data_2", data_2, x.d2);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        inst_in    = '0;
        inst_valid = 1'b0;
        flush      = 1'b0;
        wr_en      = 1'b1;
        wr_addr    = 5'd9;
        wr_data    = 32'h55;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_ctrl", {23'd0, ex, m, wb}, 32'd0);
        chk("rst_data_1", data_1, 32'd0);
        chk("rst_imm", imm, 32'd0);

        // post-reset R-type read
        drive(rtype(5'd3, 5'd4, 5'd5), 1, 0, 0, 5'd0, 0);
        @(negedge clk);
        chk("a_equal", 32'(equal), 32'd1);
        chk("a_jump", 32'(jump), 32'd0);
        chk("a_exc", 32'(exception), 32'd0);
        push(4'b1100, 3'b000, 2'b10, 3, 4, 5, 32'h2800, 0, 0);

        // bypass of a same-cycle write
        drive(rtype(5'd5, 5'd0, 5'd1), 1, 0, 1, 5'd5, 32'hDEADBEEF);
        @(negedge clk);
        chk("b_equal", 32'(equal), 32'd0);
        push(4'b1100, 3'b000, 2'b10, 5, 0, 1, 32'h0800,
             32'hDEADBEEF, 0);

        // write to r0 is dropped; r5 now stored
        drive(rtype(5'd0, 5'd5, 5'd2), 1, 0, 1, 5'd0, 32'h1234);
        @(negedge clk);
        chk("nobypass_data_1", b_d1, 32'd0);
        chk("c_equal", 32'(equal), 32'd0);
        push(4'b1100, 3'b000, 2'b10, 0, 5, 2, 32'h1000,
             0, 32'hDEADBEEF);

        // write during reset was discarded
        drive(rtype(5'd9, 5'd0, 5'd0), 1, 0, 0, 5'd0, 0);
        @(negedge clk);
        chk("d_equal", 32'(equal), 32'd1);
        push(4'b1100, 3'b000, 2'b10, 9, 0, 0, 0, 0, 0);

        // lw r7 with negative immediate, r7 written same cycle
        drive(itype(6'b100011, 5'd0, 5'd7, 16'h8001),
              1, 0, 1, 5'd7, 32'h77);
        @(negedge clk);
        chk("e_stall", 32'(stall_out), 32'd0);
        push(4'b0001, 3'b010, 2'b11, 0, 7, 16, 32'hFFFF8001,
             0, 32'h77);

        // load-use: add reads r7
        drive(rtype(5'd7, 5'd0, 5'd2), 1, 0, 0, 5'd0, 0);
        @(negedge clk);
        chk("f_stall", 32'(stall_out), 32'd1);
        chk("zext_imm", b_imm, 32'h00008001);

        drive(rtype(5'd7, 5'd0, 5'd2), 1, 0, 0, 5'd0, 0);
        @(negedge clk);
        chk("g_bubble_valid", 32'(id_valid), 32'd0);
        chk("g_bubble_m", 32'(m), 32'd0);
        chk("g_stall", 32'(stall_out), 32'd0);
        push(4'b1100, 3'b000, 2'b10, 7, 0, 2, 32'h1000, 32'h77, 0);

        // flush during a load-use stall
        drive(itype(6'b100011, 5'd0, 5'd8, 16'h0004), 1, 0, 0, 5'd0, 0);
        @(negedge clk);
        chk("h_stall", 32'(stall_out), 32'd0);
        push(4'b0001, 3'b010, 2'b11, 0, 8, 0, 32'h4, 0, 0);

        drive(rtype(5'd8, 5'd8, 5'd3), 1, 1, 0, 5'd0, 0);
        @(negedge clk);
        chk("i_stall", 32'(stall_out), 32'd1);

        drive(rtype(5'd8, 5'd8, 5'd3), 0, 0, 0, 5'd0, 0);
        @(negedge clk);
        chk("j_bubble_valid", 32'(id_valid), 32'd0);
        chk("j_stall", 32'(stall_out), 32'd0);

        // sw and beq
        drive(itype(6'b101011, 5'd5, 5'd7, 16'h0010), 1, 0, 0, 5'd0, 0);
        @(negedge clk);
        chk("k_equal", 32'(equal), 32'd0);
        push(4'b0001, 3'b001, 2'b00, 5, 7, 0, 32'h10,
             32'hDEADBEEF, 32'h77);

        drive(itype(6'b000100, 5'd7, 5'd7, 16'h0000), 1, 0, 0, 5'd0, 0);
        @(negedge clk);
        chk("l_equal", 32'(equal), 32'd1);
        push(4'b0010, 3'b100, 2'b00, 7, 7, 0, 0, 32'h77, 32'h77);

        // jump
        drive({6'b000010, 26'd0}, 1, 0, 0, 5'd0, 0);
        @(negedge clk);
        chk("m_jump", 32'(jump), 32'd1);
        chk("m_exc", 32'(exception), 32'd0);
        push(4'b0000, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0);

        // illegal opcode
        drive(itype(6'b111111, 5'd0, 5'd0, 16'h8001), 1, 0, 0, 5'd0, 0);
        @(negedge clk);
        chk("n_exc", 32'(exception), 32'd1);
        chk("n_jump", 32'(jump), 32'd0);
        push(4'b0000, 3'b000, 2'b00, 0, 0, 16, 32'hFFFF8001, 0, 0);

        // inst_valid low suppresses combinational flags
        drive(itype(6'b111111, 5'd0, 5'd0, 16'h8001), 0, 0, 0, 5'd0, 0);
        @(negedge clk);
        chk("o_exc", 32'(exception), 32'd0);
        chk("o_equal", 32'(equal), 32'd0);
        chk("o_zext_imm", b_imm, 32'h00008001);

        drive({6'b000010, 26'd0}, 0, 0, 0, 5'd0, 0);
        @(negedge clk);
        chk("p_jump", 32'(jump), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(q.size()), 32'd0);
        chk("sb_count", 32'(seen), 32'(pushed));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register/data width in bits (>= 16).
REQ-002 The block SHALL have parameter NREGS, default 32, meaning implemented registers (2..32); addresses >= NREGS read 0 and ignore writes.
REQ-003 The block SHALL have parameter SIGN_EXT, default 1, meaning imm is sign-extended from inst_in[15:0] when 1 and zero-extended when 0.
REQ-004 The block SHALL have parameter BYPASS, default 1, meaning same-cycle write-to-read forwarding in the register file is enabled when 1.
REQ-005 The block SHALL have ports, one per line as name, direction, width, meaning:
- clk  in  1  the block's one clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- inst_in  in  32  instruction from fetch.
- inst_valid  in  1  inst_in holds a real instruction this cycle.
- flush  in  1  discard the current instruction (branch/jump taken).
- wr_en  in  1  register write enable from writeback.
- wr_addr  in  5  writeback register index.
- wr_data  in  DATA_W  writeback data.
- stall_out  out  1  combinational load-use hazard; fetch must hold inst_in.
- jump  out  1  combinational; inst_valid and opcode 000010.
- exception  out  1  combinational; inst_valid and opcode not in {000000,100011,101011,000100,000010}.
- equal  out  1  combinational; forwarded read of rs equals forwarded read of rt.
- id_valid  out  1  registered; ID/EX stage holds a real instruction.
- rs, rt, rd  out  5 each  registered inst fields [25:21], [20:16], [15:11].
- imm  out  DATA_W  registered extended immediate.
- data_1, data_2  out  DATA_W  registered register reads of rs, rt.
- ex  out  4, m  out  3, wb  out  2  registered control bundles.

Function
REQ-006 The register file SHALL write wr_data to wr_addr on the clk edge when wr_en=1, wr_addr!=0 and wr_addr<NREGS; register 0 SHALL always read 0.
REQ-007 With BYPASS=1, a read whose address equals a valid, non-zero wr_addr in the same cycle SHALL return wr_data; with BYPASS=0 it SHALL return the stored value.
REQ-008 Control decode SHALL be: 000000 -> ex=1100 m=000 wb=10; 100011 -> ex=0001 m=010 wb=11; 101011 -> ex=0001 m=001 wb=00; 000100 -> ex=0010 m=100 wb=00; all others -> ex=0000 m=000 wb=00; no X values.
REQ-009 stall_out SHALL be 1 when id_valid=1, m[1]=1, rt!=0, and rt equals inst_in[25:21] or inst_in[20:16], with inst_valid=1.
REQ-010 At each edge the stage register SHALL load, by priority: rst -> reset values; flush -> bubble; stall_out -> bubble; inst_valid=0 -> bubble; otherwise capture of the decoded instruction with id_valid=1.
REQ-011 A bubble SHALL set id_valid=0 and ex/m/wb=0, and SHALL leave rs/rt/rd/imm/data_1/data_2 at don't-care values that the verifier ignores.
REQ-012 Latency SHALL be one cycle from an accepted inst_in to the id_valid/ex/m/wb outputs.
REQ-013 jump, exception, equal and stall_out SHALL be combinational, valid in the same cycle, and suppressed to 0 when inst_valid=0.
REQ-014 A simultaneous flush and stall_out SHALL produce one bubble only; flush wins.

Reset
REQ-015 While rst=1 at an edge, all registered outputs and all register-file entries SHALL become 0.
REQ-016 A write with wr_en=1 in a reset cycle SHALL be discarded.
REQ-017 Combinational outputs SHALL follow inputs during reset and SHALL reflect the cleared state in the following cycle.

Verification
REQ-018 The bench SHALL cover a post-reset read: assert rst 1 cycle, then issue R-type rs=3 rt=4 -> next cycle data_1=0, data_2=0, ex=1100, wb=10, id_valid=1.
REQ-019 The bench SHALL cover bypass: wr_en=1 wr_addr=5 wr_data=0xDEADBEEF in the same cycle as an instruction with rs=5 -> data_1=0xDEADBEEF (BYPASS=1); a write to r0 leaves r0 reading 0.
REQ-020 The bench SHALL cover load-use: lw rt=7, then add rs=7 -> stall_out=1 for one cycle, a bubble (id_valid=0, m=000), then the add captured on the next cycle.
REQ-021 The bench SHALL cover flush plus stall: flush=1 during a stall_out=1 cycle -> a single bubble and no duplicate instruction.
REQ-022 The bench SHALL cover immediate extension: imm field 0x8001 -> imm=0xFFFF8001 with SIGN_EXT=1 and 0x00008001 with SIGN_EXT=0; opcode 111111 -> exception=1, controls 0.
